// File: rtl/timer_pkg.sv
// Shared definitions for the timer family: width helper and default clock frequency.
package timer_pkg;

  localparam int unsigned DefaultClkHz = 50_000_000;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 prescaler; terminal pulses while enabled on the last count.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic terminal
);

  localparam int unsigned CntW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign terminal = enable && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/updown_tick_timer.sv
// Modulo-MODULUS up/down counter stepped at TICK_HZ, with synchronous clamped load.
module updown_tick_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = DefaultClkHz,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned MODULUS = 6,
  parameter int unsigned WIDTH   = clog2(MODULUS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             wrap
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam logic [WIDTH-1:0] OutMax = WIDTH'(MODULUS - 1);

  logic             step;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_clamped;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .clear    (load),
    .terminal (step)
  );

  assign load_clamped = (32'(load_value) >= MODULUS) ? OutMax : load_value;

  // Load has priority over a coincident step and suppresses tick/wrap.
  always_comb begin
    out_d  = out_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      out_d = load_clamped;
    end else if (step) begin
      tick_d = 1'b1;
      if (direction) begin
        if (out_q == OutMax) begin
          out_d  = '0;
          wrap_d = 1'b1;
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end else begin
        if (out_q == '0) begin
          out_d  = OutMax;
          wrap_d = 1'b1;
        end else begin
          out_d = out_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_updown_tick_timer.sv
// Directed bench for updown_tick_timer with DIV=4, MODULUS=6.
module tb_updown_tick_timer;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       direction;
  logic       load;
  logic [2:0] load_value;
  logic [2:0] out;
  logic       tick;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  updown_tick_timer #(
    .CLK_HZ  (4),
    .TICK_HZ (1),
    .MODULUS (6),
    .WIDTH   (3)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .direction  (direction),
    .load       (load),
    .load_value (load_value),
    .out        (out),
    .tick       (tick),
    .wrap       (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int exp_up[7];
    int exp_mix[6];
    int wrap_mix[6];
    exp_up   = '{1, 2, 3, 4, 5, 0, 1};
    exp_mix  = '{5, 0, 5, 4, 5, 4};
    wrap_mix = '{1, 1, 1, 0, 0, 0};

    reset_n    = 1'b0;
    enable     = 1'b0;
    direction  = 1'b1;
    load       = 1'b0;
    load_value = '0;
    #12;
    check("reset_out", int'(out), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_wrap", int'(wrap), 0);

    // Count up for 28 cycles
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      cyc();
      check("up_tick", int'(tick), (c % 4 == 0) ? 1 : 0);
      check("up_wrap", int'(wrap), (c == 24) ? 1 : 0);
      if (c % 4 == 0) check("up_out", int'(out), exp_up[c/4-1]);
    end

    // Count down from reset
    do_reset();
    direction = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      check("dn_tick", int'(tick), (c % 4 == 0) ? 1 : 0);
      check("dn_wrap", int'(wrap), (c == 4) ? 1 : 0);
    end
    check("dn_out", int'(out), 3);

    // Pause mid-period
    do_reset();
    direction = 1'b1;
    cyc();
    cyc();
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      check("pause_tick", int'(tick), 0);
    end
    check("pause_out", int'(out), 0);
    enable = 1'b1;
    cyc();
    check("resume_tick1", int'(tick), 0);
    cyc();
    check("resume_tick2", int'(tick), 1);
    check("resume_out", int'(out), 1);

    // Clamped load
    load       = 1'b1;
    load_value = 3'd7;
    cyc();
    load = 1'b0;
    check("load_clamp_out", int'(out), 5);
    check("load_clamp_tick", int'(tick), 0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check("post_load_tick", int'(tick), (c == 4) ? 1 : 0);
    end
    check("post_load_out", int'(out), 0);
    check("post_load_wrap", int'(wrap), 1);

    // Load coincident with terminal prescaler count
    cyc();
    cyc();
    cyc();
    load       = 1'b1;
    load_value = 3'd2;
    cyc();
    load = 1'b0;
    check("coinc_out", int'(out), 2);
    check("coinc_tick", int'(tick), 0);
    check("coinc_wrap", int'(wrap), 0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check("coinc_next_tick", int'(tick), (c == 4) ? 1 : 0);
    end
    check("coinc_next_out", int'(out), 3);

    // Asynchronous reset mid-period at out=3
    cyc();
    reset_n = 1'b0;
    #1;
    check("async_rst_out", int'(out), 0);
    check("async_rst_tick", int'(tick), 0);
    cyc();
    reset_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check("rel_tick", int'(tick), (c == 4) ? 1 : 0);
    end
    check("rel_out", int'(out), 1);

    // Direction toggled every 3 cycles
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      direction = (((c - 1) / 3) % 2 == 0) ? 1'b1 : 1'b0;
      cyc();
      check("tog_tick", int'(tick), (c % 4 == 0) ? 1 : 0);
      if (c % 4 == 0) begin
        check("tog_out", int'(out), exp_mix[c/4-1]);
        check("tog_wrap", int'(wrap), wrap_mix[c/4-1]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_tick_timer.md
UPDOWN_TICK_TIMER -- requirements
Module: updown_tick_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 1, meaning count-step rate in Hz; DIV = CLK_HZ/TICK_HZ, integer and >= 2.
REQ-003 The block SHALL have parameter MODULUS, default 6, meaning count range 0..MODULUS-1, with MODULUS >= 2.
REQ-004 The block SHALL have parameter WIDTH, default clog2(MODULUS), meaning count width.
REQ-005 The block SHALL have port clock, input, 1, the single clock, with all state on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port enable, input, 1, where 1 = run and 0 = pause (prescaler and count hold).
REQ-008 The block SHALL have port direction, input, 1, where 1 = count up and 0 = count down.
REQ-009 The block SHALL have port load, input, 1, a synchronous load strobe.
REQ-010 The block SHALL have port load_value, input, WIDTH, the value to load.
REQ-011 The block SHALL have port out, output, WIDTH, the current count (registered).
REQ-012 The block SHALL have port tick, output, 1, a one-cycle pulse on each count step.
REQ-013 The block SHALL have port wrap, output, 1, a one-cycle pulse when a step wraps (up: MODULUS-1->0; down: 0->MODULUS-1).

Function
REQ-014 The prescaler SHALL count 0..DIV-1 while enable=1 and return to 0 after DIV-1, giving exactly DIV enabled cycles per step.
REQ-015 A step SHALL occur on the edge where the prescaler equals DIV-1 and enable=1; out and tick/wrap SHALL update on that same edge (latency 1 cycle from the terminal prescaler value).
REQ-016 An up step SHALL set out = out+1, or 0 when out = MODULUS-1, and assert wrap for that case only.
REQ-017 A down step SHALL set out = out-1, or MODULUS-1 when out = 0, and assert wrap for that case only.
REQ-018 direction SHALL be sampled only at the step edge; a change mid-period SHALL NOT reset the prescaler.
REQ-019 With enable=0, the prescaler, out, tick and wrap SHALL hold at 0/held values (tick=wrap=0); re-enable SHALL resume the prescaler from its held value.
REQ-020 When load=1, out SHALL take load_value on the next edge and the prescaler SHALL clear to 0, regardless of enable.
REQ-021 A load_value >= MODULUS SHALL load MODULUS-1 (clamp).
REQ-022 When load and a step coincide, load SHALL win, and tick and wrap SHALL remain 0 that cycle.
REQ-023 out SHALL never hold a value >= MODULUS.
REQ-024 tick and wrap SHALL be high for exactly one clock per step and never high at the same time as a load.

Reset
REQ-025 While reset_n=0, out, the prescaler, tick and wrap SHALL be 0 asynchronously.
REQ-026 After reset_n deasserts mid-period, the first step SHALL occur exactly DIV enabled cycles later.

Structure
REQ-027 Package timer_pkg SHALL hold the clog2 function and the default CLK_HZ constant, shared with the other timer blocks.
REQ-028 The prescaler SHALL be the sub-module tick_prescaler, with parameter DIV, inputs clock, reset_n, enable and clear, and output a one-cycle terminal pulse.
REQ-029 The step, wrap and clamp logic SHALL reside in updown_tick_timer.

Verification (CLK_HZ=4, TICK_HZ=1, so DIV=4; MODULUS=6)
REQ-030 Reset then enable=1, direction=1 for 28 cycles -> out = 1,2,3,4,5,0,1 at cycles 4,8,...,28; wrap only at cycle 24.
REQ-031 direction=0 from reset -> first step gives out=5 with wrap=1, then 4,3 every 4 cycles.
REQ-032 enable=0 for 10 cycles after 2 run cycles -> no tick; step lands 2 cycles after re-enable.
REQ-033 load=1 with load_value=7 -> out=5 next edge; load coincident with terminal prescaler -> tick=0 and the next step 4 cycles later.
REQ-034 reset_n low mid-count (out=3) -> out=0 immediately without a clock edge; the next step is 4 cycles after release.
REQ-035 direction toggled every 3 cycles -> each step direction equals direction at the step edge; prescaler period unaffected.
